// File: rtl/vl_strip_seq.sv
// ---------------------------------------------------------------------------
// vl_strip_seq
//
// Strip-mining loop controller placed around a VL setup stage. It accepts one
// vector command (AVL, SEW, LMUL) and drives the setup stage from latched
// registers. Each pass samples the vl and new AVL returned by the setup stage
// and issues one strip (vl, base element index, last flag) to the execution
// unit over a valid/ready handshake. The loop repeats until the remaining AVL
// reaches zero, and then done pulses.
//
// Optional build macro: VL_STRIP_SEQ_PERF_EN
//    When defined, adds output strip_cnt[7:0]. It counts the strip handshakes
//    for the current or most recent command, saturates at 255, and is cleared
//    on command accept and on rst.
//
// Ports:
//    clk, rst            clock, synchronous active-high reset
//    cmd_valid/ready     command handshake; cmd_ready is high exactly in IDLE
//    cmd_avl/sew/lmul    command fields
//    setup_sew/lmul/avl  latched operands driven to the VL setup stage
//    setup_en            setup stage reports that SEW/LMUL are legal
//    setup_vl            vl for setup_avl (combinational from setup_*)
//    setup_new_avl       remaining AVL after this strip
//    strip_valid/ready   strip handshake to the execution unit
//    strip_vl/base/last  strip descriptor, held stable while strip_valid=1
//    done, err           one-cycle completion / abort pulses (exclusive)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready=1
// CALC  | one cycle: sample the setup stage, check it, build the strip
// ISSUE | strip_valid=1, waiting for strip_ready
// ---------------------------------------------------------------------------
module vl_strip_seq #(
   parameter int AVL_W  = 9,
   parameter int SEW_W  = 8,
   parameter int LMUL_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [AVL_W-1:0]  cmd_avl,
   input  logic [SEW_W-1:0]  cmd_sew,
   input  logic [LMUL_W-1:0] cmd_lmul,
   output logic [SEW_W-1:0]  setup_sew,
   output logic [LMUL_W-1:0] setup_lmul,
   output logic [AVL_W-1:0]  setup_avl,
   input  logic              setup_en,
   input  logic [AVL_W-1:0]  setup_vl,
   input  logic [AVL_W-1:0]  setup_new_avl,
   output logic              strip_valid,
   input  logic              strip_ready,
   output logic [AVL_W-1:0]  strip_vl,
   output logic [AVL_W-1:0]  strip_base,
   output logic              strip_last,
   output logic              done,
   output logic              err
`ifdef VL_STRIP_SEQ_PERF_EN
   ,
   output logic [7:0]        strip_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [SEW_W-1:0]  sew_q, sew_d;
   logic [LMUL_W-1:0] lmul_q, lmul_d;
   logic [AVL_W-1:0]  rem_avl_q, rem_avl_d;
   logic [AVL_W-1:0]  nxt_avl_q, nxt_avl_d;
   logic [AVL_W-1:0]  base_q, base_d;
   logic [AVL_W-1:0]  strip_vl_q, strip_vl_d;
   logic [AVL_W-1:0]  strip_base_q, strip_base_d;
   logic              strip_last_q, strip_last_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [AVL_W:0]    vl_sum;
   logic              setup_bad;

   // The sum is one bit wider so that a setup stage returning values that
   // wrap cannot look consistent.
   assign vl_sum    = {1'b0, setup_vl} + {1'b0, setup_new_avl};
   assign setup_bad = (setup_vl > rem_avl_q) || (vl_sum != {1'b0, rem_avl_q});

   always_comb begin
      state_d      = state_q;
      sew_d        = sew_q;
      lmul_d       = lmul_q;
      rem_avl_d    = rem_avl_q;
      nxt_avl_d    = nxt_avl_q;
      base_d       = base_q;
      strip_vl_d   = strip_vl_q;
      strip_base_d = strip_base_q;
      strip_last_d = strip_last_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               sew_d     = cmd_sew;
               lmul_d    = cmd_lmul;
               rem_avl_d = cmd_avl;
               base_d    = '0;
               state_d   = CALC;
            end
         end
         CALC: begin
            state_d = IDLE;
            if (!setup_en) begin
               err_d = 1'b1;
            end else if (setup_vl == '0) begin
               done_d = 1'b1;
            end else if (setup_bad) begin
               err_d = 1'b1;
            end else begin
               strip_vl_d   = setup_vl;
               strip_base_d = base_q;
               strip_last_d = (setup_new_avl == '0);
               nxt_avl_d    = setup_new_avl;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (strip_ready) begin
               base_d    = base_q + strip_vl_q;
               rem_avl_d = nxt_avl_q;
               if (strip_last_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sew_q        <= '0;
         lmul_q       <= '0;
         rem_avl_q    <= '0;
         nxt_avl_q    <= '0;
         base_q       <= '0;
         strip_vl_q   <= '0;
         strip_base_q <= '0;
         strip_last_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sew_q        <= sew_d;
         lmul_q       <= lmul_d;
         rem_avl_q    <= rem_avl_d;
         nxt_avl_q    <= nxt_avl_d;
         base_q       <= base_d;
         strip_vl_q   <= strip_vl_d;
         strip_base_q <= strip_base_d;
         strip_last_q <= strip_last_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign strip_valid = (state_q == ISSUE);
   assign setup_sew   = sew_q;
   assign setup_lmul  = lmul_q;
   assign setup_avl   = rem_avl_q;
   assign strip_vl    = strip_vl_q;
   assign strip_base  = strip_base_q;
   assign strip_last  = strip_last_q;
   assign done        = done_q;
   assign err         = err_q;

`ifdef VL_STRIP_SEQ_PERF_EN
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && cmd_valid) begin
         cnt_d = '0;
      end else if (state_q == ISSUE && strip_ready && cnt_q != 8'hFF) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign strip_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_vl_strip_seq.sv
module tb_vl_strip_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [8:0] cmd_avl;
   logic [7:0] cmd_sew;
   logic [4:0] cmd_lmul;
   logic [7:0] setup_sew;
   logic [4:0] setup_lmul;
   logic [8:0] setup_avl;
   logic       setup_en;
   logic [8:0] setup_vl;
   logic [8:0] setup_new_avl;
   logic       strip_valid;
   logic       strip_ready;
   logic [8:0] strip_vl;
   logic [8:0] strip_base;
   logic       strip_last;
   logic       done;
   logic       err;
`ifdef VL_STRIP_SEQ_PERF_EN
   logic [7:0] strip_cnt;
`endif

   int vectors    = 0;
   int miscompares = 0;
   int corrupt    = 0;

   vl_strip_seq dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_avl       (cmd_avl),
      .cmd_sew       (cmd_sew),
      .cmd_lmul      (cmd_lmul),
      .setup_sew     (setup_sew),
      .setup_lmul    (setup_lmul),
      .setup_avl     (setup_avl),
      .setup_en      (setup_en),
      .setup_vl      (setup_vl),
      .setup_new_avl (setup_new_avl),
      .strip_valid   (strip_valid),
      .strip_ready   (strip_ready),
      .strip_vl      (strip_vl),
      .strip_base    (strip_base),
      .strip_last    (strip_last),
      .done          (done),
      .err           (err)
`ifdef VL_STRIP_SEQ_PERF_EN
      ,
      .strip_cnt     (strip_cnt)
`endif
   );

   always #5 clk = ~clk;

   // VL setup stage for VLEN=128, with literal SEW and LMUL values.
   function automatic bit model_en(input int sew, input int lmul);
      return (sew == 8 || sew == 16 || sew == 32 || sew == 64 || sew == 128) &&
             (lmul == 1 || lmul == 2 || lmul == 4 || lmul == 8);
   endfunction

   function automatic int model_vlmax(input int sew, input int lmul);
      return (128 * lmul) / sew;
   endfunction

   always_comb begin
      int vm;
      int avl;
      int vl;
      vm            = 0;
      avl           = int'(setup_avl);
      vl            = 0;
      setup_en      = model_en(int'(setup_sew), int'(setup_lmul));
      if (setup_en) begin
         vm = model_vlmax(int'(setup_sew), int'(setup_lmul));
         vl = (avl < vm) ? avl : vm;
      end
      setup_vl      = 9'(vl);
      // A non-zero corrupt value makes vl + new_avl disagree with avl.
      setup_new_avl = 9'(avl - vl + corrupt);
   end

   typedef struct packed {
      logic [8:0] vl;
      logic [8:0] base;
      logic       last;
   } strip_t;

   strip_t exp_q[$];
   strip_t mon_e;

   task automatic chk(input string name, input int act, input int expv);
      vectors++;
      if (act != expv) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Scoreboard: each strip handshake is compared with the oldest expected strip.
   always @(negedge clk) begin
      if (!rst && strip_valid && strip_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strip: got vl=%0d base=%0d last=%0d expected none",
                     strip_vl, strip_base, strip_last);
         end else begin
            mon_e = exp_q.pop_front();
            if (strip_vl !== mon_e.vl || strip_base !== mon_e.base || strip_last !== mon_e.last) begin
               miscompares++;
               $display("FAIL strip: got vl=%0d base=%0d last=%0d expected vl=%0d base=%0d last=%0d",
                        strip_vl, strip_base, strip_last, mon_e.vl, mon_e.base, mon_e.last);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_strips(input int avl, input int sew, input int lmul, output int n);
      int rem;
      int base;
      int vm;
      int v;
      strip_t s;
      rem  = avl;
      base = 0;
      n    = 0;
      vm   = model_vlmax(sew, lmul);
      while (rem > 0) begin
         v      = (rem < vm) ? rem : vm;
         s.vl   = 9'(v);
         s.base = 9'(base);
         s.last = (rem == v);
         exp_q.push_back(s);
         base += v;
         rem  -= v;
         n++;
      end
   endtask

   task automatic run_cmd(input int avl, input int sew, input int lmul, input int corrupt_i,
                          input int stall_strip, input int stall_len, input int exp_n,
                          input int exp_err, input string name);
      int  cyc;
      int  hs;
      int  stalled;
      int  n;
      int  exp_cyc;
      bit  fin;
      bit  hs_now;
      n = 0;
      if (!exp_err) push_strips(avl, sew, lmul, n);
      if (exp_err || n == 0)
         exp_cyc = 2;
      else
         exp_cyc = 2 * n + 1 + ((stall_strip >= 0 && stall_strip < n) ? stall_len : 0);
      corrupt     = corrupt_i;
      cmd_avl     = 9'(avl);
      cmd_sew     = 8'(sew);
      cmd_lmul    = 5'(lmul);
      cmd_valid   = 1'b1;
      strip_ready = 1'b1;
      chk({name, "_cmd_ready_pre"}, int'(cmd_ready), 1);
      tick();
      cmd_valid = 1'b0;
      cyc       = 1;
      hs        = 0;
      stalled   = 0;
      fin       = 1'b0;
      while (!fin && cyc < 2000) begin
         if (done || err) begin
            fin = 1'b1;
         end else begin
            if (strip_valid && hs == stall_strip && stalled < stall_len) begin
               strip_ready = 1'b0;
               stalled++;
               if (exp_q.size() > 0) begin
                  chk({name, "_hold_vl"}, int'(strip_vl), int'(exp_q[0].vl));
                  chk({name, "_hold_base"}, int'(strip_base), int'(exp_q[0].base));
               end else begin
                  chk({name, "_hold_queue"}, 0, 1);
               end
            end else begin
               strip_ready = 1'b1;
            end
            hs_now = strip_valid && strip_ready;
            tick();
            cyc++;
            if (hs_now) hs++;
         end
      end
      strip_ready = 1'b1;
      corrupt     = 0;
      chk({name, "_finished"}, int'(fin), 1);
      chk({name, "_done_err"}, int'({done, err}), exp_err ? 1 : 2);
      chk({name, "_end_cycle"}, cyc, exp_cyc);
      chk({name, "_strips"}, hs, exp_n);
      chk({name, "_cmd_ready_end"}, int'(cmd_ready), 1);
      chk({name, "_pending"}, exp_q.size(), 0);
      exp_q.delete();
`ifdef VL_STRIP_SEQ_PERF_EN
      chk({name, "_strip_cnt"}, int'(strip_cnt), (exp_n > 255) ? 255 : exp_n);
`endif
   endtask

   typedef struct {
      int avl;
      int sew;
      int lmul;
      int corrupt;
      int stall_strip;
      int stall_len;
      int exp_n;
      int exp_err;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{10,  32,  1, 0, -1, 0, 3,  0};
      vecs[1]  = '{32,  8,   2, 0, -1, 0, 1,  0};
      vecs[2]  = '{0,   16,  1, 0, -1, 0, 0,  0};
      vecs[3]  = '{10,  24,  1, 0, -1, 0, 0,  1};
      vecs[4]  = '{10,  32,  1, 0,  1, 5, 3,  0};
      vecs[5]  = '{100, 8,   1, 0, -1, 0, 7,  0};
      vecs[6]  = '{511, 8,   8, 0, -1, 0, 4,  0};
      vecs[7]  = '{7,   32,  1, 1, -1, 0, 0,  1};
      vecs[8]  = '{5,   16,  3, 0, -1, 0, 0,  1};
      vecs[9]  = '{20,  128, 1, 0,  0, 2, 20, 0};
      vecs[10] = '{6,   64,  4, 0, -1, 0, 1,  0};

      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_avl     = '0;
      cmd_sew     = '0;
      cmd_lmul    = '0;
      strip_ready = 1'b0;
      tick();
      tick();
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_strip_valid", int'(strip_valid), 0);
      chk("rst_done_err", int'({done, err}), 0);
      chk("rst_setup", int'({setup_sew, setup_lmul, setup_avl}), 0);
      chk("rst_strip", int'({strip_vl, strip_base, strip_last}), 0);
      rst = 1'b0;
      tick();

      // Consecutive commands are issued in each done/err cycle (back-to-back accept).
      for (int i = 0; i < 11; i++) begin
         run_cmd(vecs[i].avl, vecs[i].sew, vecs[i].lmul, vecs[i].corrupt,
                 vecs[i].stall_strip, vecs[i].stall_len, vecs[i].exp_n,
                 vecs[i].exp_err, $sformatf("vec%0d", i));
      end
      tick();
      chk("pulse_drop", int'({done, err}), 0);

      // Reset while the second strip is waiting in ISSUE.
      begin
         strip_t s;
         s.vl   = 9'd4;
         s.base = 9'd0;
         s.last = 1'b0;
         exp_q.push_back(s);
      end
      cmd_avl     = 9'd10;
      cmd_sew     = 8'd32;
      cmd_lmul    = 5'd1;
      cmd_valid   = 1'b1;
      strip_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      strip_ready = 1'b0;
      tick();
      chk("rst_mid_valid", int'(strip_valid), 1);
      chk("rst_mid_base", int'(strip_base), 4);
      chk("rst_mid_popped", exp_q.size(), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_strip_valid", int'(strip_valid), 0);
      chk("rst_mid_cmd_ready", int'(cmd_ready), 1);
      chk("rst_mid_done_err", int'({done, err}), 0);
      chk("rst_mid_avl", int'(setup_avl), 0);
`ifdef VL_STRIP_SEQ_PERF_EN
      chk("rst_mid_strip_cnt", int'(strip_cnt), 0);
`endif
      strip_ready = 1'b1;
      tick();
      chk("rst_mid_quiet", int'({done, err, strip_valid}), 0);
      run_cmd(6, 32, 1, 0, -1, 0, 2, 0, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
